// File: rtl/medidor_faixa_n_fd.sv
// medidor_faixa_n_fd: periodic range watch with miss-tolerant filter, dwell timer and ASCII report frame
module medidor_faixa_n_fd #(
  parameter int DIGITS      = 3,
  parameter int PERIOD_CYC  = 5_000_000,
  parameter int DWELL_CYC   = 150_000_000,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int MISS_MAX    = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar,
  input  logic                modo,
  input  logic [4*DIGITS-1:0] upperL,
  input  logic [4*DIGITS-1:0] lowerL,
  input  logic [4*DIGITS-1:0] medida,
  input  logic                medida_pronto,
  input  logic                tx_pronto,
  output logic                medir,
  output logic                tx_partida,
  output logic [6:0]          tx_dado,
  output logic                dentro,
  output logic                acertou,
  output logic                erro,
  output logic                ocupado,
  output logic [4*DIGITS-1:0] db_medida,
  output logic [3:0]          db_estado
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam int MW = $clog2(MISS_MAX + 2);
  localparam int IW = $clog2(DIGITS + 2);
  localparam logic [PW-1:0] PER_END  = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYC - 1);
  localparam logic [DW-1:0] DW_END   = DW'(DWELL_CYC - 1);
  localparam logic [MW-1:0] MISS_END = MW'(MISS_MAX);
  localparam logic [IW-1:0] LAST     = IW'(DIGITS + 1);
  typedef enum logic [3:0] {
    OCIOSO, MEDE, ESPERA_MEDIDA, AVALIA, TX, ESPERA_TX, PROX_CHAR, ESPERA_PERIODO
  } estado_t;
  estado_t       st_q, st_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] to_q, to_d;
  logic [DW-1:0] dw_q, dw_d;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  med_q, med_d;
  logic          erro_q, erro_d, dentro_q, dentro_d, acertou_q, acertou_d, ligar_q;
  logic          in_range;
  logic [3:0]    nib;
  logic [6:0]    chr;
  // Current frame character; the counters treat the MEDE cycle as count 0
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) nib = (idx_q == IW'(i)) ? med_q[4*(DIGITS-1-i) +: 4] : nib;
    in_range = !erro_q && med_q >= lowerL && med_q <= upperL;
    chr = idx_q < IW'(DIGITS) ? {3'b011, nib} :
          idx_q == IW'(DIGITS) ? (erro_q ? 7'h45 : dentro_q ? 7'h44 : 7'h46) : 7'h23;
  end
  // Sequencer next state, measurement latch, filter and dwell timer
  always_comb begin
    st_d      = st_q;
    med_d     = med_q;
    erro_d    = erro_q;
    dentro_d  = dentro_q;
    miss_d    = miss_q;
    idx_d     = idx_q;
    miss_inc  = miss_q + 1'b1;
    per_d     = st_q == MEDE ? PW'(1) : per_q >= PER_END ? per_q : per_q + 1'b1;
    to_d      = st_q == MEDE ? TW'(1) : to_q >= TO_END ? to_q : to_q + 1'b1;
    dw_d      = !dentro_q ? DW'(0) : dw_q >= DW_END ? dw_q : dw_q + 1'b1;
    acertou_d = dentro_q && dw_q >= DW_END;
    case (st_q)
      OCIOSO:         st_d = (modo ? ligar && !ligar_q : ligar) ? MEDE : OCIOSO;
      MEDE:           st_d = ESPERA_MEDIDA;
      ESPERA_MEDIDA: begin
        st_d   = medida_pronto || to_q >= TO_END ? AVALIA : ESPERA_MEDIDA;
        med_d  = medida_pronto ? medida : med_q;
        erro_d = medida_pronto ? 1'b0 : to_q >= TO_END ? 1'b1 : erro_q;
      end
      AVALIA: begin
        st_d     = TX;
        dentro_d = in_range ? 1'b1 : miss_inc > MISS_END ? 1'b0 : dentro_q;
        miss_d   = in_range || miss_inc > MISS_END ? MW'(0) : miss_inc;
      end
      TX:             st_d = ESPERA_TX;
      ESPERA_TX:      st_d = tx_pronto ? PROX_CHAR : ESPERA_TX;
      PROX_CHAR: begin
        st_d  = idx_q == LAST ? ESPERA_PERIODO : TX;
        idx_d = idx_q == LAST ? IW'(0) : idx_q + 1'b1;
      end
      ESPERA_PERIODO: st_d = modo || !ligar ? OCIOSO : per_q >= PER_END ? MEDE : ESPERA_PERIODO;
      default:        st_d = OCIOSO;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st_q      <= OCIOSO;
      per_q     <= '0;
      to_q      <= '0;
      dw_q      <= '0;
      miss_q    <= '0;
      idx_q     <= '0;
      med_q     <= '0;
      erro_q    <= 1'b0;
      dentro_q  <= 1'b0;
      acertou_q <= 1'b0;
      ligar_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      per_q     <= per_d;
      to_q      <= to_d;
      dw_q      <= dw_d;
      miss_q    <= miss_d;
      idx_q     <= idx_d;
      med_q     <= med_d;
      erro_q    <= erro_d;
      dentro_q  <= dentro_d;
      acertou_q <= acertou_d;
      ligar_q   <= ligar;
    end
  assign medir      = st_q == MEDE;
  assign tx_partida = st_q == TX;
  assign tx_dado    = (st_q == TX || st_q == ESPERA_TX) ? chr : 7'h00;
  assign dentro     = dentro_q;
  assign acertou    = acertou_q;
  assign erro       = erro_q;
  assign ocupado    = st_q != OCIOSO;
  assign db_medida  = med_q;
  assign db_estado  = st_q;
endmodule

// File: tb/tb_medidor_faixa_n_fd.sv
// tb_medidor_faixa_n_fd: scoreboard bench with sensor and transmitter models for the range-watch datapath
module tb_medidor_faixa_n_fd;
  logic        clock = 1'b0, reset = 1'b1, ligar = 1'b0, modo = 1'b0;
  logic [11:0] upperL = 12'h050, lowerL = 12'h010, medida = 12'h000;
  logic        medida_pronto = 1'b0, tx_pronto = 1'b0;
  logic        medir, tx_partida, dentro, acertou, erro, ocupado;
  logic [6:0]  tx_dado;
  logic [11:0] db_medida;
  logic [3:0]  db_estado;
  int checks = 0, failures = 0;
  int cyc = 0, n_medir = 0, last_medir = 0, d_rise = 0, a_rise = 0, d_fall = 0, a_fall = 0, e_rise = 0, n_drise = 0;
  int mt_q[$];
  int sens_q[$];
  logic [6:0] exp_q[$];
  int s_cnt = 0, t_cnt = 0, v;
  logic [11:0] s_val = 12'h000;
  logic [6:0] e;
  logic pd = 1'b0, pa = 1'b0, pe = 1'b0;

  medidor_faixa_n_fd #(.DIGITS(3), .PERIOD_CYC(200), .DWELL_CYC(50), .TIMEOUT_CYC(100), .MISS_MAX(1)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .modo(modo), .upperL(upperL), .lowerL(lowerL),
    .medida(medida), .medida_pronto(medida_pronto), .tx_pronto(tx_pronto), .medir(medir),
    .tx_partida(tx_partida), .tx_dado(tx_dado), .dentro(dentro), .acertou(acertou), .erro(erro),
    .ocupado(ocupado), .db_medida(db_medida), .db_estado(db_estado));

  always #5 clock = ~clock;

  // Event monitor, sensor model (3-cycle reply), transmitter model (pronto 5 clk after partida) and char scoreboard
  always @(negedge clock) begin
    cyc++;
    tx_pronto = 1'b0;
    medida_pronto = 1'b0;
    if (dentro && !pd) begin d_rise = cyc; n_drise++; end
    if (!dentro && pd) d_fall = cyc;
    if (acertou && !pa) a_rise = cyc;
    if (!acertou && pa) a_fall = cyc;
    if (erro && !pe) e_rise = cyc;
    pd = dentro; pa = acertou; pe = erro;
    if (medir) begin n_medir++; last_medir = cyc; mt_q.push_back(cyc); end
    if (reset) begin
      s_cnt = 0;
      t_cnt = 0;
    end else begin
      if (s_cnt != 0) begin
        s_cnt--;
        if (s_cnt == 0) begin medida = s_val; medida_pronto = 1'b1; end
      end else if (medir && sens_q.size() != 0) begin
        v = sens_q.pop_front();
        if (v >= 0) begin s_val = v[11:0]; s_cnt = 3; end
      end
      if (t_cnt != 0) begin
        t_cnt--;
        if (t_cnt == 0) tx_pronto = 1'b1;
      end else if (tx_partida) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_char unexpected: got %h, none expected", tx_dado);
        end else begin
          e = exp_q.pop_front();
          if (tx_dado !== e) begin failures++; $display("FAIL tx_char: got %h, expected %h", tx_dado, e); end
        end
        t_cnt = 5;
      end
    end
  end

  task tick;
    @(negedge clock);
    #1;
  endtask

  task push_frame(input logic [11:0] m, input logic [6:0] s);
    exp_q.push_back({3'b011, m[11:8]});
    exp_q.push_back({3'b011, m[7:4]});
    exp_q.push_back({3'b011, m[3:0]});
    exp_q.push_back(s);
    exp_q.push_back(7'h23);
  endtask

  task wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      ok = !ocupado;
    end
  endtask

  task wait_medir(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      ok = n_medir >= target;
    end
  endtask

  task shot(input int sample, output bit ok);
    sens_q.push_back(sample);
    ligar = 1'b0;
    repeat (2) tick;
    ligar = 1'b1;
    tick;
    wait_idle(600, ok);
  endtask

  task do_reset;
    reset = 1'b1;
    ligar = 1'b0;
    sens_q.delete();
    exp_q.delete();
    repeat (2) tick;
    reset = 1'b0;
    tick;
  endtask

  task test_reset;
    reset = 1'b1;
    repeat (3) tick;
    checks++; if ({medir, tx_partida, dentro, acertou, erro, ocupado} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b, expected 000000", {medir, tx_partida, dentro, acertou, erro, ocupado}); end
    checks++; if (tx_dado !== 7'h00) begin failures++; $display("FAIL reset_tx_dado: got %h, expected 00", tx_dado); end
    checks++; if (db_medida !== 12'h000) begin failures++; $display("FAIL reset_db_medida: got %h, expected 000", db_medida); end
    checks++; if (db_estado !== 4'h0) begin failures++; $display("FAIL reset_db_estado: got %0d, expected 0", db_estado); end
    reset = 1'b0;
    repeat (3) tick;
    checks++; if (db_estado !== 4'h0) begin failures++; $display("FAIL idle_without_ligar: got %0d, expected 0", db_estado); end
  endtask

  task test_single_shot;
    bit ok;
    int base;
    modo = 1'b1; lowerL = 12'h010; upperL = 12'h050;
    base = n_medir;
    push_frame(12'h025, 7'h44);
    shot('h025, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle: got busy, expected idle"); end
    checks++; if (n_medir - base != 1) begin failures++; $display("FAIL single_medir_count: got %0d, expected 1", n_medir - base); end
    checks++; if (db_medida !== 12'h025) begin failures++; $display("FAIL single_db_medida: got %h, expected 025", db_medida); end
    checks++; if (dentro !== 1'b1) begin failures++; $display("FAIL single_dentro: got %b, expected 1", dentro); end
    repeat (300) tick;
    checks++; if (n_medir - base != 1) begin failures++; $display("FAIL single_no_repeat: got %0d, expected 1", n_medir - base); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_frame_len: got %0d left, expected 0", exp_q.size()); end
    ligar = 1'b0;
  endtask

  task test_continuous;
    bit ok;
    int base, nd0;
    modo = 1'b0; lowerL = 12'h010; upperL = 12'h050;
    base = n_medir; nd0 = n_drise;
    mt_q.delete();
    repeat (4) begin sens_q.push_back('h025); push_frame(12'h025, 7'h44); end
    ligar = 1'b1;
    wait_medir(base + 4, 1200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cont_medir_timeout: got %0d, expected 4", n_medir - base); end
    ligar = 1'b0;
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cont_idle: got busy, expected idle"); end
    checks++; if (mt_q.size() != 4) begin failures++; $display("FAIL cont_medir_total: got %0d, expected 4", mt_q.size()); end
    for (int i = 1; i < mt_q.size(); i++) begin
      checks++; if (mt_q[i] - mt_q[i-1] != 200) begin failures++; $display("FAIL cont_period: got %0d, expected 200", mt_q[i] - mt_q[i-1]); end
    end
    checks++; if (n_drise - nd0 != 1) begin failures++; $display("FAIL cont_dentro_rises: got %0d, expected 1", n_drise - nd0); end
    checks++; if (a_rise - d_rise != 50) begin failures++; $display("FAIL dwell_latency: got %0d, expected 50", a_rise - d_rise); end
    checks++; if (acertou !== 1'b1) begin failures++; $display("FAIL dwell_held: got %b, expected 1", acertou); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cont_frames: got %0d left, expected 0", exp_q.size()); end
  endtask

  task test_miss_filter;
    bit ok;
    int base, df0;
    logic [11:0] smp [5];
    logic [6:0]  st  [5];
    smp = '{12'h025, 12'h099, 12'h025, 12'h099, 12'h099};
    st  = '{7'h44, 7'h44, 7'h44, 7'h44, 7'h46};
    modo = 1'b0;
    base = n_medir; df0 = d_fall;
    for (int i = 0; i < 5; i++) begin sens_q.push_back(int'(smp[i])); push_frame(smp[i], st[i]); end
    ligar = 1'b1;
    wait_medir(base + 5, 1500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL miss_medir_timeout: got %0d, expected 5", n_medir - base); end
    ligar = 1'b0;
    wait_idle(400, ok);
    checks++; if (dentro !== 1'b0) begin failures++; $display("FAIL miss_dentro: got %b, expected 0", dentro); end
    checks++; if (d_fall == df0) begin failures++; $display("FAIL miss_dentro_fell: got no fall, expected one"); end
    checks++; if (a_fall - d_fall != 1) begin failures++; $display("FAIL miss_acertou_lag: got %0d, expected 1", a_fall - d_fall); end
    checks++; if (acertou !== 1'b0) begin failures++; $display("FAIL miss_acertou: got %b, expected 0", acertou); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL miss_frames: got %0d left, expected 0", exp_q.size()); end
  endtask

  task test_timeout;
    bit ok;
    modo = 1'b1; lowerL = 12'h010; upperL = 12'h050;
    push_frame(12'h025, 7'h44);
    shot('h025, ok);
    checks++; if (dentro !== 1'b1) begin failures++; $display("FAIL to_pre_dentro: got %b, expected 1", dentro); end
    push_frame(12'h025, 7'h45);
    shot(-1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_idle: got busy, expected idle"); end
    checks++; if (erro !== 1'b1) begin failures++; $display("FAIL to_erro: got %b, expected 1", erro); end
    checks++; if (db_medida !== 12'h025) begin failures++; $display("FAIL to_db_medida: got %h, expected 025", db_medida); end
    checks++; if (dentro !== 1'b1) begin failures++; $display("FAIL to_one_miss: got %b, expected 1", dentro); end
    checks++; if (e_rise - last_medir != 100) begin failures++; $display("FAIL to_latency: got %0d, expected 100", e_rise - last_medir); end
    push_frame(12'h025, 7'h45);
    shot(-1, ok);
    checks++; if (dentro !== 1'b0) begin failures++; $display("FAIL to_two_miss: got %b, expected 0", dentro); end
    push_frame(12'h025, 7'h44);
    shot('h025, ok);
    checks++; if (erro !== 1'b0) begin failures++; $display("FAIL to_erro_clear: got %b, expected 0", erro); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL to_frames: got %0d left, expected 0", exp_q.size()); end
  endtask

  task test_inverted;
    bit ok;
    int nd0;
    modo = 1'b1; lowerL = 12'h060; upperL = 12'h020;
    nd0 = n_drise;
    repeat (2) begin push_frame(12'h040, 7'h46); shot('h040, ok); end
    checks++; if (db_medida !== 12'h040) begin failures++; $display("FAIL inv_db_medida: got %h, expected 040", db_medida); end
    checks++; if (n_drise != nd0 || dentro !== 1'b0) begin failures++; $display("FAIL inv_dentro: got %0d rises, expected 0", n_drise - nd0); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL inv_frames: got %0d left, expected 0", exp_q.size()); end
    ligar = 1'b0;
  endtask

  task test_reset_mid;
    bit ok;
    int base;
    modo = 1'b0; lowerL = 12'h010; upperL = 12'h050;
    sens_q.push_back('h025);
    exp_q.push_back(7'h30);
    ligar = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin tick; ok = db_estado == 4'd5; end
    checks++; if (!ok) begin failures++; $display("FAIL rst_reach_espera_tx: got %0d, expected 5", db_estado); end
    reset = 1'b1;
    #1;
    checks++; if ({medir, tx_partida, dentro, acertou, erro, ocupado, tx_dado} !== 13'b0) begin failures++; $display("FAIL rst_mid_outputs: got %b, expected 0", {medir, tx_partida, dentro, acertou, erro, ocupado, tx_dado}); end
    checks++; if (db_estado !== 4'h0 || db_medida !== 12'h000) begin failures++; $display("FAIL rst_mid_state: got %0d/%h, expected 0/000", db_estado, db_medida); end
    repeat (2) tick;
    base = n_medir;
    sens_q.push_back('h025);
    push_frame(12'h025, 7'h44);
    reset = 1'b0;
    wait_medir(base + 1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_restart_medir: got %0d, expected 1", n_medir - base); end
    ligar = 1'b0;
    wait_idle(400, ok);
    checks++; if (db_medida !== 12'h025 || dentro !== 1'b1) begin failures++; $display("FAIL rst_restart_result: got %h/%b, expected 025/1", db_medida, dentro); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_frames: got %0d left, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single_shot;
    do_reset;
    test_continuous;
    test_miss_filter;
    test_timeout;
    do_reset;
    test_inverted;
    do_reset;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
